canny_hysteresis: RTL and testbench

- Final Canny stage, directly downstream of non-maximal suppression.
- Consumes the suppressed magnitude stream (0 = suppressed, 255 = strong edge, anything else = weak edge) in raster order.
- Resolves weak pixels against their 3x3 neighbourhood using internal line buffers and emits a binary edge map (0/255).
- A frame-tail flush emits the last row without needing extra input.

---
 rtl/canny_hysteresis.sv | 219 +++++++++++++++++++++
 tb/tb_canny_hysteresis.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_hysteresis.sv
// Canny hysteresis stage: classifies suppressed magnitudes, resolves weak pixels
// against a masked 3x3 neighbourhood and emits a 0/STRONG_VAL edge map in raster order.
module canny_hysteresis #(
  parameter int                PIC_WIDTH  = 250,
  parameter int                PIC_HEIGHT = 250,
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  STRONG_VAL = WIDTH'(255)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] dout,
  output logic             frame_done
);

  localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
  // Input rows run one past the frame during the flush, hence the +2.
  localparam int RW = $clog2(PIC_HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d;
  logic [RW-1:0]   in_row_q, in_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  cls_e            win_q [3][3];
  cls_e            win_d [3][3];
  cls_e            lb0_q [PIC_WIDTH];
  cls_e            lb0_d [PIC_WIDTH];
  cls_e            lb1_q [PIC_WIDTH];
  cls_e            lb1_d [PIC_WIDTH];
  logic            valid_out_q, valid_out_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic            frame_done_q, frame_done_d;

  logic            accept;
  logic            shift;
  cls_e            new_cls;
  logic            produce;
  logic            clear;
  logic            in_last;
  logic            out_last;
  logic            fill_done;
  logic            row_ok [3];
  logic            col_ok [3];
  logic            strong_nb;
  logic            is_edge;

  // Synthetic NONE pixels are shifted in during the flush so the last row resolves.
  always_comb begin
    accept  = valid_in && (state_q != S_FLUSH);
    shift   = accept || (state_q == S_FLUSH);
    new_cls = CLS_NONE;
    if (accept) begin
      if (din == '0)              new_cls = CLS_NONE;
      else if (din == STRONG_VAL) new_cls = CLS_STRONG;
      else                        new_cls = CLS_WEAK;
    end
  end

  assign in_last   = (in_col_q == COL_LAST) && (in_row_q == ROW_LAST);
  assign out_last  = (out_col_q == COL_LAST) && (out_row_q == ROW_LAST);
  assign fill_done = (in_row_q == RW'(1)) && (in_col_q == CW'(1));

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    produce = 1'b0;
    clear   = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL: begin
        if (accept && fill_done) begin
          state_d = S_RUN;
          produce = 1'b1;
        end
      end
      S_RUN: begin
        if (accept) begin
          produce = 1'b1;
          if (in_last) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        produce = 1'b1;
        if (out_last) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (shift) begin
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
    if (produce) begin
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
    if (clear) begin
      in_col_d  = '0;
      in_row_d  = '0;
      out_col_d = '0;
      out_row_d = '0;
    end
  end

  // Window row 2 is the newest line; lb1 holds the pixel one line back, lb0 two lines back.
  always_comb begin
    win_d = win_q;
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2]     = lb0_q[in_col_q];
      win_d[1][2]     = lb1_q[in_col_q];
      win_d[2][2]     = new_cls;
      lb0_d[in_col_q] = lb1_q[in_col_q];
      lb1_d[in_col_q] = new_cls;
    end
  end

  // Masking follows the centre's own coordinates, which also blocks line wrap-around.
  always_comb begin
    row_ok[0] = (out_row_q != '0);
    row_ok[1] = 1'b1;
    row_ok[2] = (out_row_q != ROW_LAST);
    col_ok[0] = (out_col_q != '0);
    col_ok[1] = 1'b1;
    col_ok[2] = (out_col_q != COL_LAST);
    strong_nb = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1) && row_ok[r] && col_ok[c] && (win_d[r][c] == CLS_STRONG))
          strong_nb = 1'b1;
      end
    end
    is_edge = (win_d[1][1] == CLS_STRONG) || ((win_d[1][1] == CLS_WEAK) && strong_nb);
    valid_out_d  = produce;
    dout_d       = (produce && is_edge) ? STRONG_VAL : '0;
    frame_done_d = produce && out_last;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      valid_out_q  <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= CLS_NONE;
      // NOTE: the line buffers are flop arrays cleared on reset, so they cannot map to RAM.
      for (int i = 0; i < PIC_WIDTH; i++) begin
        lb0_q[i] <= CLS_NONE;
        lb1_q[i] <= CLS_NONE;
      end
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      valid_out_q  <= valid_out_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
      lb0_q        <= lb0_d;
      lb1_q        <= lb1_d;
    end
  end

  assign busy       = (state_q == S_FLUSH);
  assign valid_out  = valid_out_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_canny_hysteresis.sv
// Self-checking bench for canny_hysteresis: directed 4x3 frames and random 8x6 frames with
// stalls, compared against a per-pixel neighbourhood model of the edge decision.
module tb_canny_hysteresis;

  localparam int AW = 4;
  localparam int AH = 3;
  localparam int BW = 8;
  localparam int BH = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       va, vb;
  logic [7:0] da, db;
  logic       busy_a, vout_a, fdone_a;
  logic       busy_b, vout_b, fdone_b;
  logic [7:0] dout_a, dout_b;

  logic       sel_b;
  logic       cur_busy, cur_vout, cur_fdone;
  logic [7:0] cur_dout;

  int checks   = 0;
  int failures = 0;

  int img_q[$];
  int exp_q[$];
  int cap_q[$];
  int ref_q[$];

  always #5 clk = ~clk;

  canny_hysteresis #(.PIC_WIDTH(AW), .PIC_HEIGHT(AH), .WIDTH(8), .STRONG_VAL(8'd255)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(va), .din(da),
    .busy(busy_a), .valid_out(vout_a), .dout(dout_a), .frame_done(fdone_a)
  );

  canny_hysteresis #(.PIC_WIDTH(BW), .PIC_HEIGHT(BH), .WIDTH(8), .STRONG_VAL(8'd255)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(vb), .din(db),
    .busy(busy_b), .valid_out(vout_b), .dout(dout_b), .frame_done(fdone_b)
  );

  assign cur_busy  = sel_b ? busy_b  : busy_a;
  assign cur_vout  = sel_b ? vout_b  : vout_a;
  assign cur_fdone = sel_b ? fdone_b : fdone_a;
  assign cur_dout  = sel_b ? dout_b  : dout_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: strong centre, or weak centre with a strong in-image 8-neighbour.
  function automatic void build_expected(input int w, input int h);
    exp_q = {};
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int ctr;
        int e;
        ctr = img_q[r*w + c];
        e   = 0;
        if (ctr == 255) e = 255;
        else if (ctr != 0) begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < h && c+dc >= 0 && c+dc < w)
                if (img_q[(r+dr)*w + c+dc] == 255) e = 255;
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic drive(input bit v, input logic [7:0] d);
    if (!sel_b) begin
      va = v;
      da = d;
    end else begin
      vb = v;
      db = d;
    end
  endtask

  task automatic gen_random(input int n);
    img_q = {};
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(9);
      if (r < 4)      img_q.push_back(0);
      else if (r < 6) img_q.push_back(255);
      else            img_q.push_back($urandom_range(254, 1));
    end
  endtask

  task automatic fill_const(input int n, input int v);
    img_q = {};
    for (int i = 0; i < n; i++) img_q.push_back(v);
  endtask

  // Streams img_q into the selected DUT and checks every output cycle.
  task automatic run_frame(input int w, input int h, input int gap_pct, input bit junk,
                           input string tag);
    int   idx, outs, busy_cyc, done_cnt, cyc, first_acc, timing_errs, prev_idx;
    bit   prev_acc, prev_busy, exp_v, v;
    logic [7:0] d;
    idx = 0; outs = 0; busy_cyc = 0; done_cnt = 0; cyc = 0; first_acc = -1;
    timing_errs = 0; prev_idx = 0; prev_acc = 0; prev_busy = 0;
    build_expected(w, h);
    cap_q = {};
    while (cyc < 20*w*h + 200) begin
      @(negedge clk);
      cyc++;
      exp_v = prev_busy || (prev_acc && prev_idx >= w + 1);
      if (cur_vout !== exp_v) timing_errs++;
      if (cur_vout === 1'b1) begin
        if (outs == 0) first_acc = idx;
        if (outs < exp_q.size()) check({tag, "_dout"}, cur_dout, exp_q[outs]);
        if (cur_fdone !== (outs == w*h - 1)) timing_errs++;
        cap_q.push_back(int'(cur_dout));
        outs++;
      end else if (cur_fdone !== 1'b0) timing_errs++;
      if (cur_fdone === 1'b1) done_cnt++;
      if (cur_busy === 1'b1) busy_cyc++;
      if (outs == w*h) break;
      prev_busy = (cur_busy === 1'b1);
      v = 1'b0;
      d = 8'd0;
      if (idx < w*h && !prev_busy) begin
        if ($urandom_range(99) >= gap_pct) begin
          v = 1'b1;
          d = 8'(img_q[idx]);
        end
      end else if (prev_busy && junk) begin
        v = 1'b1;
        d = 8'($urandom);
      end
      drive(v, d);
      prev_acc = v && !prev_busy;
      prev_idx = idx;
      if (prev_acc) idx++;
    end
    drive(1'b0, 8'd0);
    check({tag, "_outputs"},     outs,        w*h);
    check({tag, "_busy_cycles"}, busy_cyc,    w + 1);
    check({tag, "_frame_done"},  done_cnt,    1);
    check({tag, "_valid_timing"}, timing_errs, 0);
    check({tag, "_first_out_acc"}, first_acc, w + 2);
    check({tag, "_busy_end"},    cur_busy,    0);
  endtask

  initial begin
    rst_n = 1'b0;
    va = 1'b0; vb = 1'b0; da = 8'd0; db = 8'd0;
    sel_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vout_a", vout_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_fdone_a", fdone_a, 0);
    check("rst_vout_b", vout_b, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // All suppressed.
    fill_const(AW*AH, 0);
    run_frame(AW, AH, 0, 1'b0, "zero");
    for (int i = 0; i < cap_q.size(); i++) check("zero_val", cap_q[i], 0);

    // Weak field with one strong pixel at (1,1).
    fill_const(AW*AH, 100);
    img_q[1*AW + 1] = 255;
    run_frame(AW, AH, 0, 1'b0, "block");
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++)
        if (r*AW + c < cap_q.size())
          check("block_val", cap_q[r*AW + c], (c <= 2) ? 255 : 0);

    // Line wrap must not connect (0,3) to (1,0).
    fill_const(AW*AH, 0);
    img_q[3] = 255;
    img_q[4] = 100;
    run_frame(AW, AH, 0, 1'b0, "wrap");
    if (cap_q.size() > 4) begin
      check("wrap_03", cap_q[3], 255);
      check("wrap_10", cap_q[4], 0);
    end

    // Single pass: weak chain only resolves next to the strong pixel.
    fill_const(AW*AH, 0);
    img_q[4] = 255; img_q[5] = 100; img_q[6] = 100; img_q[7] = 100;
    run_frame(AW, AH, 0, 1'b0, "chain");
    if (cap_q.size() > 7) begin
      check("chain_10", cap_q[4], 255);
      check("chain_11", cap_q[5], 255);
      check("chain_12", cap_q[6], 0);
      check("chain_13", cap_q[7], 0);
    end

    // Random 8x6 image, gap-free then stalled with junk during busy.
    sel_b = 1'b1;
    @(negedge clk);
    gen_random(BW*BH);
    run_frame(BW, BH, 0, 1'b0, "rnd");
    ref_q = cap_q;
    run_frame(BW, BH, 40, 1'b1, "stall");
    check("stall_len", cap_q.size(), ref_q.size());
    for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
      check("stall_vs_gapfree", cap_q[i], ref_q[i]);
    gen_random(BW*BH);
    run_frame(BW, BH, 25, 1'b1, "rnd2");

    // Reset in the middle of a frame after 7 accepts.
    sel_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'($urandom));
      @(negedge clk);
    end
    check("pre_rst_vout", vout_a, 1);
    drive(1'b0, 8'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_vout", vout_a, 0);
    check("mid_rst_dout", dout_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_fdone", fdone_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gen_random(AW*AH);
    run_frame(AW, AH, 20, 1'b1, "after_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
